ctrl_seq_fsm: RTL and testbench

- Multi-cycle sequencing control unit for the MiniCPU. Successor to the single-cycle combinational opcode decoder.
- Accepts instructions over a valid/ready handshake and walks each one through FETCH/DECODE/EXECUTE/WRITEBACK.
- Drives the ALU select, ALU enable, register write enable and PC increment; waits for the ALU to finish multi-cycle operations.
- Sits between the instruction source (IR/memory) and the ALU/register file.

---
 rtl/ctrl_seq_fsm_pkg.sv | 39 +++
 rtl/ctrl_seq_fsm_if.sv | 23 ++
 rtl/ctrl_seq_fsm_decode.sv | 38 +++
 rtl/ctrl_seq_fsm.sv | 146 ++++++++++++++
 tb/tb_ctrl_seq_fsm.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_seq_fsm_pkg.sv
// ctrl_pkg: shared types and constants for the MiniCPU sequencing control unit.
// State encoding, opcode map and ALU select codes live here so the decoder,
// the FSM and any future users agree on a single definition.
package ctrl_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_e;

    // Opcode map. These values are zero-extended to OPCODE_W before any compare.
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_NOP  = 4;
    localparam int unsigned OP_XOR  = 5;
    localparam int unsigned OP_SHL  = 6;
    localparam int unsigned OP_SHR  = 7;
    localparam int unsigned OP_HALT = 15;

    // ALU select codes. These values are zero-extended to ALU_SEL_W.
    localparam int unsigned SEL_ADD = 0;
    localparam int unsigned SEL_SUB = 1;
    localparam int unsigned SEL_AND = 2;
    localparam int unsigned SEL_OR  = 3;
    localparam int unsigned SEL_XOR = 4;
    localparam int unsigned SEL_SHL = 5;
    localparam int unsigned SEL_SHR = 6;

    // Width of the EXECUTE wait counter; covers EXEC_TIMEOUT up to 255.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/ctrl_seq_fsm_if.sv
// ctrl_seq_fsm_if: instruction handshake plus ALU control bundle.
// master = instruction source / ALU side, slave = the sequencing control unit.
interface ctrl_seq_fsm_if #(
    parameter int OPCODE_W  = 4,
    parameter int ALU_SEL_W = 3
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [OPCODE_W-1:0]  opcode;
    logic                 alu_done;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 alu_en;

    modport master (
        output instr_valid, opcode, alu_done,
        input  instr_ready, alu_sel, alu_en
    );

    modport slave (
        input  instr_valid, opcode, alu_done,
        output instr_ready, alu_sel, alu_en
    );
endinterface

// File: rtl/ctrl_seq_fsm_decode.sv
// ctrl_decode: purely combinational opcode decoder.
// Maps an opcode to its ALU select, write-back flag, HALT flag and illegal flag.
// NOP, HALT and illegal codes all decode to select 0 with no write-back.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALU_SEL_W = 3
) (
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 wb,
    output logic                 is_halt,
    output logic                 is_illegal
);

    // Opcode lookup; every code outside the map falls through to illegal.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
        alu_sel    = '0;
        wb         = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        unique case (opcode)
            OPCODE_W'(OP_ADD):  begin alu_sel = ALU_SEL_W'(SEL_ADD); wb = 1'b1; end
            OPCODE_W'(OP_SUB):  begin alu_sel = ALU_SEL_W'(SEL_SUB); wb = 1'b1; end
            OPCODE_W'(OP_AND):  begin alu_sel = ALU_SEL_W'(SEL_AND); wb = 1'b1; end
            OPCODE_W'(OP_OR):   begin alu_sel = ALU_SEL_W'(SEL_OR);  wb = 1'b1; end
            OPCODE_W'(OP_NOP):  ;
            OPCODE_W'(OP_XOR):  begin alu_sel = ALU_SEL_W'(SEL_XOR); wb = 1'b1; end
            OPCODE_W'(OP_SHL):  begin alu_sel = ALU_SEL_W'(SEL_SHL); wb = 1'b1; end
            OPCODE_W'(OP_SHR):  begin alu_sel = ALU_SEL_W'(SEL_SHR); wb = 1'b1; end
            OPCODE_W'(OP_HALT): is_halt = 1'b1;
            default:            is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_seq_fsm.sv
// ctrl_seq_fsm: multi-cycle sequencing control unit for the MiniCPU.
// Walks each accepted instruction through FETCH/DECODE/EXECUTE/WRITEBACK,
// drives ALU select/enable, register write and PC increment, and aborts an
// EXECUTE that waits EXEC_TIMEOUT cycles for alu_done.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT
// with a sticky illegal_op flag; otherwise illegal opcodes retire as NOP.
module ctrl_seq_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int ALU_SEL_W    = 3,
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    ctrl_seq_fsm_if.slave  bus,
    input  logic           resume,
    output logic           reg_write,
    output logic           pc_inc,
    output logic           busy,
    output logic           halted,
    output logic           timeout
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic           illegal_op
`endif
);

    // Counter value seen in the last permitted EXECUTE cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

    state_e               state;
    state_e               state_nxt;
    logic [OPCODE_W-1:0]  ir;
    logic [ALU_SEL_W-1:0] alu_sel_q;
    logic                 wb_q;
    logic [CNT_W-1:0]     exec_cnt;
    logic                 ready;
    logic                 alu_en;

    logic [ALU_SEL_W-1:0] dec_sel;
    logic                 dec_wb;
    logic                 dec_halt;
    logic                 dec_illegal;

    ctrl_decode #(
        .OPCODE_W  (OPCODE_W),
        .ALU_SEL_W (ALU_SEL_W)
    ) u_decode (
        .opcode     (ir),
        .alu_sel    (dec_sel),
        .wb         (dec_wb),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        alu_en    = 1'b0;
        reg_write = 1'b0;
        pc_inc    = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                ready = 1'b1;
                if (bus.instr_valid) state_nxt = DECODE;
            end
            DECODE: begin
                if (dec_halt)                      state_nxt = HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                else if (dec_illegal)              state_nxt = HALT;
`endif
                // Only operations that write back need the ALU; NOP and
                // illegal codes go straight to WRITEBACK to retire.
                else if (!dec_wb || dec_illegal)   state_nxt = WRITEBACK;
                else                               state_nxt = EXECUTE;
            end
            EXECUTE: begin
                alu_en = 1'b1;
                // alu_done has priority over an expiring wait.
                if (bus.alu_done) begin
                    state_nxt = WRITEBACK;
                end else if (exec_cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = WRITEBACK;
                end
            end
            WRITEBACK: begin
                reg_write = wb_q;
                pc_inc    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: begin
                if (resume) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction register, registered decode results and EXECUTE wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: IR and the decode registers are plain flops, cleared on reset so no stale write-back survives it.
        if (!rst_n) begin
            ir        <= '0;
            alu_sel_q <= '0;
            wb_q      <= 1'b0;
            exec_cnt  <= '0;
        end else begin
            if (state == FETCH && bus.instr_valid) ir <= bus.opcode;
            if (state == DECODE) begin
                alu_sel_q <= dec_sel;
                wb_q      <= dec_wb;
                exec_cnt  <= '0;
            end
            if (state == EXECUTE && !bus.alu_done) exec_cnt <= exec_cnt + 1'b1;
            // An aborted operation must not update the register file.
            if (timeout) wb_q <= 1'b0;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, set on decode and cleared when HALT is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              illegal_op <= 1'b0;
        else if (state == DECODE && dec_illegal) illegal_op <= 1'b1;
        else if (state == HALT && resume)        illegal_op <= 1'b0;
    end
`endif

    assign bus.instr_ready = ready;
    assign bus.alu_sel     = alu_sel_q;
    assign bus.alu_en      = alu_en;
    assign busy            = (state == DECODE) || (state == EXECUTE) || (state == WRITEBACK);
    assign halted          = (state == HALT);

endmodule

// File: tb/tb_ctrl_seq_fsm.sv
// tb_ctrl_seq_fsm: directed self-checking bench for ctrl_seq_fsm.
// Expected values are hand-derived from the instruction timing:
// handshake edge -> DECODE -> EXECUTE (n cycles) -> WRITEBACK -> FETCH.
module tb_ctrl_seq_fsm;

    logic clk = 1'b0;
    logic rst_n;
    logic resume;
    logic reg_write;
    logic pc_inc;
    logic busy;
    logic halted;
    logic timeout;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    ctrl_seq_fsm_if #(.OPCODE_W(4), .ALU_SEL_W(3)) bus ();

    ctrl_seq_fsm #(
        .OPCODE_W     (4),
        .ALU_SEL_W    (3),
        .EXEC_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .resume     (resume),
        .reg_write  (reg_write),
        .pc_inc     (pc_inc),
        .busy       (busy),
        .halted     (halted),
        .timeout    (timeout)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an opcode for one handshake edge; returns with the DUT in DECODE.
    task automatic issue(input logic [3:0] op);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        step();
        bus.instr_valid = 1'b0;
        bus.opcode      = 4'hA;
    endtask

    initial begin
        rst_n           = 1'b1;
        resume          = 1'b0;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.alu_done    = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();

        // Reset state: everything quiet.
        check("rst_ready",   32'(bus.instr_ready), 0);
        check("rst_alu_sel", 32'(bus.alu_sel),     0);
        check("rst_alu_en",  32'(bus.alu_en),      0);
        check("rst_regwr",   32'(reg_write),       0);
        check("rst_pcinc",   32'(pc_inc),          0);
        check("rst_busy",    32'(busy),            0);
        check("rst_halted",  32'(halted),          0);
        check("rst_timeout", 32'(timeout),         0);

        // Release: IDLE for one cycle, then FETCH.
        rst_n = 1'b1;
        check("idle_ready", 32'(bus.instr_ready), 0);
        step();
        check("fetch_ready", 32'(bus.instr_ready), 1);

        // ADD with alu_done already high: minimum latency.
        bus.alu_done = 1'b1;
        issue(4'd0);
        check("add_dec_ready", 32'(bus.instr_ready), 0);
        check("add_dec_busy",  32'(busy),            1);
        check("add_dec_regwr", 32'(reg_write),       0);
        step();
        check("add_ex_en",    32'(bus.alu_en),  1);
        check("add_ex_sel",   32'(bus.alu_sel), 0);
        check("add_ex_regwr", 32'(reg_write),   0);
        step();
        bus.alu_done = 1'b0;
        check("add_wb_regwr", 32'(reg_write),  1);
        check("add_wb_pcinc", 32'(pc_inc),     1);
        check("add_wb_en",    32'(bus.alu_en), 0);
        step();
        check("add_fetch_ready", 32'(bus.instr_ready), 1);
        check("add_fetch_regwr", 32'(reg_write),       0);
        check("add_fetch_pcinc", 32'(pc_inc),          0);

        // SUB with alu_done arriving in the sixth EXECUTE cycle.
        issue(4'd1);
        step();
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                bus.alu_done = 1'b1;
                #1;
            end
            check($sformatf("sub_ex%0d_en", i),    32'(bus.alu_en),  1);
            check($sformatf("sub_ex%0d_sel", i),   32'(bus.alu_sel), 1);
            check($sformatf("sub_ex%0d_regwr", i), 32'(reg_write),   0);
            check($sformatf("sub_ex%0d_to", i),    32'(timeout),     0);
            step();
        end
        bus.alu_done = 1'b0;
        check("sub_wb_regwr", 32'(reg_write),  1);
        check("sub_wb_en",    32'(bus.alu_en), 0);
        step();
        check("sub_after_regwr", 32'(reg_write),       0);
        check("sub_after_ready", 32'(bus.instr_ready), 1);

        // NOP: DECODE then straight to WRITEBACK.
        issue(4'd4);
        check("nop_dec_en", 32'(bus.alu_en), 0);
        step();
        check("nop_wb_pcinc", 32'(pc_inc),     1);
        check("nop_wb_regwr", 32'(reg_write),  0);
        check("nop_wb_en",    32'(bus.alu_en), 0);
        step();
        check("nop_fetch_ready", 32'(bus.instr_ready), 1);

        // SHR with no alu_done: 15 EXECUTE cycles, timeout on the last one.
        issue(4'd7);
        step();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("shr_ex%0d_en", i), 32'(bus.alu_en),  1);
            check($sformatf("shr_ex%0d_to", i), 32'(timeout),     (i == 15) ? 1 : 0);
            if (i == 1) check("shr_sel", 32'(bus.alu_sel), 6);
            step();
        end
        check("shr_wb_to",    32'(timeout),   0);
        check("shr_wb_regwr", 32'(reg_write), 0);
        check("shr_wb_pcinc", 32'(pc_inc),    1);
        step();
        check("shr_fetch_ready", 32'(bus.instr_ready), 1);

        // XOR with alu_done in the 15th cycle: done beats timeout.
        issue(4'd5);
        step();
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) begin
                bus.alu_done = 1'b1;
                #1;
            end
            check($sformatf("xor_ex%0d_to", i), 32'(timeout), 0);
            step();
        end
        bus.alu_done = 1'b0;
        check("xor_wb_regwr", 32'(reg_write), 1);
        check("xor_wb_pcinc", 32'(pc_inc),    1);
        step();

        // HALT, held for four cycles, then resume.
        issue(4'd15);
        step();
        bus.instr_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("halt%0d_halted", i), 32'(halted),          1);
            check($sformatf("halt%0d_ready", i),  32'(bus.instr_ready), 0);
            check($sformatf("halt%0d_pcinc", i),  32'(pc_inc),          0);
            check($sformatf("halt%0d_busy", i),   32'(busy),            0);
            step();
        end
        bus.instr_valid = 1'b0;
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", 32'(halted),          0);
        check("resume_ready",  32'(bus.instr_ready), 1);

        // Reset in the middle of an OR.
        issue(4'd3);
        step();
        check("or_ex_en",  32'(bus.alu_en),  1);
        check("or_ex_sel", 32'(bus.alu_sel), 3);
        rst_n = 1'b0;
        #1;
        check("or_rst_en",    32'(bus.alu_en),      0);
        check("or_rst_sel",   32'(bus.alu_sel),     0);
        check("or_rst_busy",  32'(busy),            0);
        check("or_rst_ready", 32'(bus.instr_ready), 0);
        bus.alu_done = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("or_post_regwr", 32'(reg_write),       0);
        check("or_post_pcinc", 32'(pc_inc),          0);
        check("or_post_ready", 32'(bus.instr_ready), 1);
        step();
        check("or_post2_regwr", 32'(reg_write), 0);
        check("or_post2_pcinc", 32'(pc_inc),    0);
        bus.alu_done = 1'b0;

        // Illegal opcode 9.
        issue(4'd9);
        step();
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("ill_flag",   32'(illegal_op), 1);
        check("ill_halted", 32'(halted),     1);
        check("ill_pcinc",  32'(pc_inc),     0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("ill_clr_flag",  32'(illegal_op),      0);
        check("ill_clr_ready", 32'(bus.instr_ready), 1);
`else
        check("ill_pcinc",  32'(pc_inc),     1);
        check("ill_regwr",  32'(reg_write),  0);
        check("ill_en",     32'(bus.alu_en), 0);
        check("ill_halted", 32'(halted),     0);
        step();
        check("ill_ready",  32'(bus.instr_ready), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
